// File: rtl/loader_pkg.sv
// Shared state encoding and word geometry for the ROM boot loader.
package loader_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LANE_BITS  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWrite,
        StDone,
        StError
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Lane-indexed byte accumulator: builds one little-endian word plus its byte enables.
module byte_packer
    import loader_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    capture,
    input  logic [LANE_BITS-1:0]    lane,
    input  logic [7:0]              byte_in,
    output logic [8*WORD_BYTES-1:0] data,
    output logic [WORD_BYTES-1:0]   enable
);

    // Clear wins over capture so an aborted word never leaves stale lanes behind.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data   <= '0;
            enable <= '0;
        end else if (clear) begin
            data   <= '0;
            enable <= '0;
        end else if (capture) begin
            data[{lane, 3'b000} +: 8] <= byte_in;
            enable[lane]              <= 1'b1;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Boot copy engine: streams ROM bytes into 32-bit memory writes and holds the CPU in reset
// until the whole image has landed.
module rom_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned MAX_BYTES    = 65536
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] rom_address,
    input  logic [7:0]  rom_byte,
    input  logic        rom_done,
    output logic        mem_write_valid,
    input  logic        mem_write_ready,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_byte_enable,
    output logic        busy,
    output logic        load_complete,
    output logic        load_error,
    output logic        cpu_reset_hold,
    output logic [31:0] byte_count
);

    localparam logic [31:0] BASE_ALIGNED = {BASE_ADDRESS[31:2], 2'b00};
    localparam logic [31:0] MAX_COUNT    = 32'(MAX_BYTES);

    loader_state_t state, state_next;
    logic [31:0] address_next, count_next;
    logic last_byte, last_byte_next;
    logic pack_clear, pack_capture, at_limit;
    logic [LANE_BITS-1:0] lane;

    assign lane     = rom_address[LANE_BITS-1:0];
    assign at_limit = (byte_count + 32'd1 == MAX_COUNT) && !rom_done;

    always_comb begin
        state_next     = state;
        address_next   = rom_address;
        count_next     = byte_count;
        last_byte_next = last_byte;
        pack_clear     = 1'b0;
        pack_capture   = 1'b0;
        unique case (state)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_next     = StFetch;
                    address_next   = '0;
                    count_next     = '0;
                    last_byte_next = 1'b0;
                    pack_clear     = 1'b1;
                end
            end
            StFetch: begin
                pack_capture = 1'b1;
                count_next   = byte_count + 32'd1;
                if (at_limit) begin
                    // Overrun: the partial word is thrown away, never written.
                    state_next = StError;
                    pack_clear = 1'b1;
                end else if (lane == LANE_BITS'(WORD_BYTES - 1) || rom_done) begin
                    state_next     = StWrite;
                    last_byte_next = rom_done;
                end else begin
                    address_next = rom_address + 32'd1;
                end
            end
            StWrite: begin
                if (mem_write_ready) begin
                    if (last_byte) begin
                        state_next = StDone;
                    end else begin
                        state_next   = StFetch;
                        address_next = rom_address + 32'd1;
                        pack_clear   = 1'b1;
                    end
                end
            end
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            rom_address <= '0;
            byte_count  <= '0;
            last_byte   <= 1'b0;
        end else begin
            state       <= state_next;
            rom_address <= address_next;
            byte_count  <= count_next;
            last_byte   <= last_byte_next;
        end
    end

    byte_packer u_packer (
        .clock   (clock),
        .reset   (reset),
        .clear   (pack_clear),
        .capture (pack_capture),
        .lane    (lane),
        .byte_in (rom_byte),
        .data    (mem_write_data),
        .enable  (mem_write_byte_enable)
    );

    assign mem_write_valid   = (state == StWrite);
    assign mem_write_address = mem_write_valid ? BASE_ALIGNED + {rom_address[31:2], 2'b00}
                                               : 32'h0;
    assign busy              = (state == StFetch) || (state == StWrite);
    assign load_complete     = (state == StDone);
    assign load_error        = (state == StError);
    assign cpu_reset_hold    = (state != StDone);

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: three parameterisations driven from a table of load scenarios.
module tb_rom_loader;

    localparam int NI = 3;

    typedef struct {
        int inst;
        int done_at;      // -1: ROM never flags done
        bit image;        // use the fixed 118-byte image
        bit toggle;       // ready alternates 1/0 every cycle
        int glitch;       // busy cycle at which to pulse start, -1 for none
        int exp_writes;
        int exp_cycles;   // -1: not checked
        bit exp_err;
        int exp_count;
    } case_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start    [NI];
    logic        rom_done [NI];
    logic        ready    [NI];
    logic        valid    [NI];
    logic        busy     [NI];
    logic        complete [NI];
    logic        err      [NI];
    logic        hold     [NI];
    logic [31:0] rom_address [NI];
    logic [31:0] waddr [NI];
    logic [31:0] wdata [NI];
    logic [31:0] count [NI];
    logic [7:0]  rom_byte [NI];
    logic [3:0]  wen [NI];
    logic [7:0]  rom_mem [NI][256];
    int          done_at [NI];

    logic [7:0]  img [256];
    logic [31:0] rec_a [64];
    logic [31:0] rec_d [64];
    logic [3:0]  rec_e [64];
    int          rec_n;
    int          checks = 0;
    int          failures = 0;
    case_t       cases [8];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign rom_byte[g] = rom_mem[g][rom_address[g][7:0]];
        assign rom_done[g] = (done_at[g] >= 0) && (rom_address[g] == 32'(done_at[g]));

        rom_loader #(
            .BASE_ADDRESS (g == 1 ? 32'h0000_1000 : 32'h0000_0000),
            .MAX_BYTES    (g == 2 ? 8 : 65536)
        ) u_dut (
            .clock                 (clock),
            .reset                 (reset),
            .start                 (start[g]),
            .rom_address           (rom_address[g]),
            .rom_byte              (rom_byte[g]),
            .rom_done              (rom_done[g]),
            .mem_write_valid       (valid[g]),
            .mem_write_ready       (ready[g]),
            .mem_write_address     (waddr[g]),
            .mem_write_data        (wdata[g]),
            .mem_write_byte_enable (wen[g]),
            .busy                  (busy[g]),
            .load_complete         (complete[g]),
            .load_error            (err[g]),
            .cpu_reset_hold        (hold[g]),
            .byte_count            (count[g])
        );
    end

    function automatic logic [31:0] base_of(input int i);
        return (i == 1) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset(input int i);
        check($sformatf("rst%0d_rom_address", i), rom_address[i], 32'h0);
        check($sformatf("rst%0d_valid", i), 32'(valid[i]), 32'h0);
        check($sformatf("rst%0d_waddr", i), waddr[i], 32'h0);
        check($sformatf("rst%0d_wdata", i), wdata[i], 32'h0);
        check($sformatf("rst%0d_wen", i), 32'(wen[i]), 32'h0);
        check($sformatf("rst%0d_busy", i), 32'(busy[i]), 32'h0);
        check($sformatf("rst%0d_complete", i), 32'(complete[i]), 32'h0);
        check($sformatf("rst%0d_error", i), 32'(err[i]), 32'h0);
        check($sformatf("rst%0d_hold", i), 32'(hold[i]), 32'h1);
        check($sformatf("rst%0d_count", i), count[i], 32'h0);
    endtask

    task automatic load_rom(input case_t c);
        for (int j = 0; j < 256; j++)
            rom_mem[c.inst][j] = c.image ? img[j] : 8'($urandom);
        if (c.done_at == 0) rom_mem[c.inst][0] = 8'hAB;
        done_at[c.inst] = c.done_at;
    endtask

    task automatic run_case(input case_t c, input string tag);
        int i;
        int cyc;
        bit fin;
        bit prev_stall;
        logic [31:0] sa, sd, sr;
        logic [3:0] se;
        i = c.inst;
        cyc = 0;
        fin = 1'b0;
        prev_stall = 1'b0;
        sa = '0; sd = '0; sr = '0; se = '0;
        rec_n = 0;
        @(negedge clock);
        start[i] = 1'b1;
        ready[i] = 1'b1;
        @(negedge clock);
        start[i] = 1'b0;
        check({tag, "_start_busy"}, 32'(busy[i]), 32'h1);
        check({tag, "_start_complete"}, 32'(complete[i]), 32'h0);
        check({tag, "_start_hold"}, 32'(hold[i]), 32'h1);
        check({tag, "_start_addr"}, rom_address[i], 32'h0);
        for (int k = 0; k < 2000 && !fin; k++) begin
            if (k > 0) @(negedge clock);
            if (complete[i] || err[i]) begin
                fin = 1'b1;
            end else begin
                if (busy[i]) cyc++;
                start[i] = (c.glitch == cyc);
                if (c.toggle) ready[i] = (k % 2 == 0);
                if (prev_stall && valid[i]) begin
                    check({tag, "_stall_waddr"}, waddr[i], sa);
                    check({tag, "_stall_wdata"}, wdata[i], sd);
                    check({tag, "_stall_wen"}, 32'(wen[i]), 32'(se));
                    check({tag, "_stall_rom_addr"}, rom_address[i], sr);
                end
                if (valid[i] && ready[i] && rec_n < 64) begin
                    rec_a[rec_n] = waddr[i];
                    rec_d[rec_n] = wdata[i];
                    rec_e[rec_n] = wen[i];
                    rec_n++;
                end
                prev_stall = valid[i] && !ready[i];
                sa = waddr[i];
                sd = wdata[i];
                se = wen[i];
                sr = rom_address[i];
            end
        end
        start[i] = 1'b0;
        ready[i] = 1'b0;
        check({tag, "_finished"}, 32'(fin), 32'h1);
        if (c.exp_cycles >= 0) check({tag, "_cycles"}, 32'(cyc), 32'(c.exp_cycles));
        check({tag, "_byte_count"}, count[i], 32'(c.exp_count));
        check({tag, "_error"}, 32'(err[i]), 32'(c.exp_err));
        check({tag, "_complete"}, 32'(complete[i]), 32'(!c.exp_err));
        check({tag, "_hold"}, 32'(hold[i]), 32'(c.exp_err));
        check({tag, "_write_count"}, 32'(rec_n), 32'(c.exp_writes));
        for (int w = 0; w < c.exp_writes && w < rec_n; w++) begin
            logic [31:0] ed;
            logic [3:0]  ee;
            ed = '0;
            ee = '0;
            for (int j = 0; j < 4; j++) begin
                if (c.done_at < 0 || 4 * w + j <= c.done_at) begin
                    ed[8*j +: 8] = rom_mem[i][4*w+j];
                    ee[j] = 1'b1;
                end
            end
            check($sformatf("%s_w%0d_addr", tag, w), rec_a[w], base_of(i) + 32'(4 * w));
            check($sformatf("%s_w%0d_data", tag, w), rec_d[w], ed);
            check($sformatf("%s_w%0d_en", tag, w), 32'(rec_e[w]), 32'(ee));
        end
    endtask

    initial begin
        int len;
        bit seen;
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0;
            ready[i] = 1'b0;
            done_at[i] = -1;
            for (int j = 0; j < 256; j++) rom_mem[i][j] = 8'h00;
        end
        for (int j = 0; j < 256; j++) img[j] = 8'($urandom);
        img[0] = 8'h0E; img[1] = 8'h14; img[2] = 8'h0F; img[3] = 8'h00;
        img[4] = 8'h00; img[5] = 8'h00; img[6] = 8'h01; img[7] = 8'h00;
        img[116] = 8'h00; img[117] = 8'h00;

        len = $urandom_range(9, 200);
        //          inst done  img tog glitch writes cycles err count
        cases[0] = '{0, 117,     1, 0,  -1, 30, 148, 0, 118};
        cases[1] = '{0, 117,     1, 0,  -1, 30, 148, 0, 118};
        cases[2] = '{1, 117,     1, 1,  -1, 30,  -1, 0, 118};
        cases[3] = '{0, 0,       0, 0,  -1,  1,   2, 0,   1};
        cases[4] = '{2, -1,      0, 0,  -1,  1,   9, 1,   8};
        cases[5] = '{0, 7,       0, 0,   2,  2,  10, 0,   8};
        cases[6] = '{0, len - 1, 0, 0,  -1, (len + 3) / 4,
                     5 * (len / 4) + len % 4 + ((len % 4 != 0) ? 1 : 0), 0, len};
        cases[7] = '{2, 5,       0, 0,  -1,  2,   8, 0,   6};

        #12;
        for (int i = 0; i < NI; i++) check_reset(i);
        @(negedge clock);
        reset = 1'b0;

        for (int r = 0; r < 8; r++) begin
            load_rom(cases[r]);
            run_case(cases[r], $sformatf("case%0d", r));
            if (r == 0) begin
                check("img_w0_data", rec_d[0], 32'h000F140E);
                check("img_w0_en", 32'(rec_e[0]), 32'hF);
                check("img_w1_addr", rec_a[1], 32'h4);
                check("img_w1_data", rec_d[1], 32'h00010000);
                check("img_last_addr", rec_a[29], 32'h74);
                check("img_last_data", rec_d[29], 32'h0);
                check("img_last_en", 32'(rec_e[29]), 32'h3);
            end else if (r == 2) begin
                check("base_w0_addr", rec_a[0], 32'h1000);
                check("base_last_addr", rec_a[29], 32'h1074);
            end else if (r == 3) begin
                check("one_byte_data", rec_d[0], 32'h000000AB);
                check("one_byte_en", 32'(rec_e[0]), 32'h1);
            end
        end

        // Reset pulsed while a write is stalled, then reload from scratch.
        load_rom(cases[0]);
        @(negedge clock);
        start[0] = 1'b1;
        ready[0] = 1'b0;
        @(negedge clock);
        start[0] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (valid[0]) seen = 1'b1;
            else @(negedge clock);
        end
        check("stall_write_pending", 32'(seen), 32'h1);
        #2 reset = 1'b1;
        #1 check_reset(0);
        @(negedge clock);
        reset = 1'b0;
        run_case(cases[0], "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
